// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel pipeline.
// The generator (master) consumes the pixel-advance enable and drives the
// counts, coordinates, sync levels and line/frame strobes.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          en;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output hcount, vcount, x, y, active, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output en,
        input  hcount, vcount, x, y, active, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Horizontal/vertical counters step on enabled pixel-clock edges. Every
// decoded output (active, x, y, syncs, strobes) is computed from the
// next-state counts and registered alongside them, so all outputs describe
// the same raster position in the same cycle.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CW       = 10
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ZERO     = CW'(0);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    // True when pos lies in the inclusive window [first, last].
    function automatic logic in_window(
        input logic [CW-1:0] pos,
        input logic [CW-1:0] first,
        input logic [CW-1:0] last
    );
        return (pos >= first) && (pos <= last);
    endfunction

    logic [CW-1:0] hcount_r;
    logic [CW-1:0] vcount_r;
    logic [CW-1:0] x_r;
    logic [CW-1:0] y_r;
    logic          active_r;
    logic          hsync_r;
    logic          vsync_r;
    logic          line_start_r;
    logic          frame_start_r;

    logic          h_wrap_s;
    logic [CW-1:0] h_next_s;
    logic [CW-1:0] v_next_s;
    logic          active_next_s;
    logic [CW-1:0] x_next_s;
    logic [CW-1:0] y_next_s;
    logic          hsync_next_s;
    logic          vsync_next_s;
    logic          line_start_next_s;
    logic          frame_start_next_s;

    // Next raster position and everything decoded from it.
    always_comb begin
        h_wrap_s           = 1'b0;
        h_next_s           = hcount_r;
        v_next_s           = vcount_r;
        active_next_s      = 1'b0;
        x_next_s           = ZERO;
        y_next_s           = ZERO;
        hsync_next_s       = ~SYNC_ON;
        vsync_next_s       = ~SYNC_ON;
        line_start_next_s  = 1'b0;
        frame_start_next_s = 1'b0;

        // Wrap by comparison with the last count, never by overflow.
        h_wrap_s = (hcount_r == H_LAST);
        if (h_wrap_s) begin
            h_next_s = ZERO;
            if (vcount_r == V_LAST) begin
                v_next_s = ZERO;
            end else begin
                v_next_s = vcount_r + ONE;
            end
        end else begin
            h_next_s = hcount_r + ONE;
            v_next_s = vcount_r;
        end

        active_next_s = (h_next_s < H_ACT_C) && (v_next_s < V_ACT_C);
        if (active_next_s) begin
            x_next_s = h_next_s;
            y_next_s = v_next_s;
        end else begin
            x_next_s = ZERO;
            y_next_s = ZERO;
        end

        if (in_window(h_next_s, HS_FIRST, HS_LAST)) begin
            hsync_next_s = SYNC_ON;
        end else begin
            hsync_next_s = ~SYNC_ON;
        end

        if (in_window(v_next_s, VS_FIRST, VS_LAST)) begin
            vsync_next_s = SYNC_ON;
        end else begin
            vsync_next_s = ~SYNC_ON;
        end

        line_start_next_s  = (h_next_s == ZERO);
        frame_start_next_s = line_start_next_s && (v_next_s == ZERO);
    end

    // Output register: load the next position on enabled edges, hold levels
    // otherwise; strobes always clear on a non-advancing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_r      <= H_LAST;
            vcount_r      <= V_LAST;
            x_r           <= ZERO;
            y_r           <= ZERO;
            active_r      <= 1'b0;
            hsync_r       <= ~SYNC_ON;
            vsync_r       <= ~SYNC_ON;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (bus.en) begin
            hcount_r      <= h_next_s;
            vcount_r      <= v_next_s;
            x_r           <= x_next_s;
            y_r           <= y_next_s;
            active_r      <= active_next_s;
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            line_start_r  <= line_start_next_s;
            frame_start_r <= frame_start_next_s;
        end else begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign bus.hcount      = hcount_r;
    assign bus.vcount      = vcount_r;
    assign bus.x           = x_r;
    assign bus.y           = y_r;
    assign bus.active      = active_r;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.line_start  = line_start_r;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small 8x4
// instance share clock, reset and enable. An arithmetic raster model
// (enabled-edge count -> position) is compared on every negedge, and
// directed literal expectations pin the model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en;

    int compared   = 0;
    int mismatched = 0;

    // Model state: enabled edges since reset, and whether the last edge advanced.
    int n_edges = 0;
    bit adv     = 1'b0;

    vga_timing_gen_if #(.CW(10)) bus_d ();
    vga_timing_gen_if #(.CW(4))  bus_s ();

    assign bus_d.en = en;
    assign bus_s.en = en;

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .SYNC_POL(0), .CW(10)
    ) dut_d (
        .clk(clk), .reset(reset), .bus(bus_d.master)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1), .CW(4)
    ) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the raster rules: position = (n-1) mod frame length.
    task automatic model_cmp(
        input string tag,
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb, input int pol,
        input logic [31:0] hc, input logic [31:0] vc,
        input logic [31:0] xo, input logic [31:0] yo,
        input logic act, input logic hsy, input logic vsy,
        input logic ls, input logic fs
    );
        int ht, vt, ft, p, h, v, e_act, e_ls;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        ft = ht * vt;
        p  = (n_edges + ft - 1) % ft;
        h  = p % ht;
        v  = p / ht;
        e_act = (h < ha && v < va) ? 1 : 0;
        e_ls  = (adv && h == 0) ? 1 : 0;
        chk({tag, ".hcount"}, hc, h);
        chk({tag, ".vcount"}, vc, v);
        chk({tag, ".active"}, {31'd0, act}, e_act);
        chk({tag, ".x"}, xo, e_act ? h : 0);
        chk({tag, ".y"}, yo, e_act ? v : 0);
        chk({tag, ".hsync"}, {31'd0, hsy},
            (h >= ha + hf && h < ha + hf + hs) ? pol : 1 - pol);
        chk({tag, ".vsync"}, {31'd0, vsy},
            (v >= va + vf && v < va + vf + vs) ? pol : 1 - pol);
        chk({tag, ".line_start"}, {31'd0, ls}, e_ls);
        chk({tag, ".frame_start"}, {31'd0, fs}, (e_ls == 1 && v == 0) ? 1 : 0);
    endtask

    // Model: count enabled edges; reset restarts the count.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n_edges <= 0;
            adv     <= 1'b0;
        end else if (en) begin
            n_edges <= n_edges + 1;
            adv     <= 1'b1;
        end else begin
            adv     <= 1'b0;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        model_cmp("dflt", 640, 16, 96, 48, 480, 10, 2, 33, 0,
                  32'(bus_d.hcount), 32'(bus_d.vcount), 32'(bus_d.x), 32'(bus_d.y),
                  bus_d.active, bus_d.hsync, bus_d.vsync,
                  bus_d.line_start, bus_d.frame_start);
        model_cmp("small", 8, 2, 3, 1, 4, 1, 2, 1, 1,
                  32'(bus_s.hcount), 32'(bus_s.vcount), 32'(bus_s.x), 32'(bus_s.y),
                  bus_s.active, bus_s.hsync, bus_s.vsync,
                  bus_s.line_start, bus_s.frame_start);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  s_active_cnt  = 0;
    int  d_hsync_cnt   = 0;
    int  d_ls_cnt      = 0;
    int  s_ls_cnt      = 0;
    int  s_fs_cnt      = 0;
    logic prev_ls      = 1'b0;
    bit  found         = 1'b0;

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        repeat (3) tick();

        // Reset state, hand-computed.
        chk("rst.s.hcount", 32'(bus_s.hcount), 13);
        chk("rst.s.vcount", 32'(bus_s.vcount), 7);
        chk("rst.s.hsync", {31'd0, bus_s.hsync}, 0);
        chk("rst.d.hcount", 32'(bus_d.hcount), 799);
        chk("rst.d.vcount", 32'(bus_d.vcount), 524);
        chk("rst.d.hsync", {31'd0, bus_d.hsync}, 1);
        chk("rst.d.active", {31'd0, bus_d.active}, 0);

        // Continuous enable.
        reset = 1'b0;
        en    = 1'b1;
        for (int k = 1; k <= 1700; k++) begin
            tick();
            if (k <= 112 && bus_s.active)    s_active_cnt++;
            if (k <= 800 && !bus_d.hsync)    d_hsync_cnt++;
            if (k <= 1600 && bus_d.line_start) d_ls_cnt++;
            if (k <= 1600 && bus_s.line_start) s_ls_cnt++;
            if (k <= 1600 && bus_s.frame_start) s_fs_cnt++;
            if (k == 1) begin
                chk("first.s.hv", {16'(bus_s.hcount), 16'(bus_s.vcount)}, 0);
                chk("first.s.strobes", {29'd0, bus_s.active, bus_s.line_start, bus_s.frame_start}, 7);
                chk("first.d.strobes", {29'd0, bus_d.active, bus_d.line_start, bus_d.frame_start}, 7);
            end
            if (k == 8)   chk("s.x7", 32'(bus_s.x), 7);
            if (k == 9)   chk("s.x_after_active", {27'd0, bus_s.active, bus_s.x}, 0);
            if (k == 11)  chk("s.hsync_h10", {28'(bus_s.hcount), 3'd0, bus_s.hsync}, 161);
            if (k == 13)  chk("s.hsync_h12", {28'(bus_s.hcount), 3'd0, bus_s.hsync}, 193);
            if (k == 14)  chk("s.hsync_h13", {28'(bus_s.hcount), 3'd0, bus_s.hsync}, 208);
            if (k == 71)  chk("s.vsync_v5", {28'(bus_s.vcount), 3'd0, bus_s.vsync}, 81);
            if (k == 98)  chk("s.vsync_v6", {28'(bus_s.vcount), 3'd0, bus_s.vsync}, 97);
            if (k == 99)  chk("s.vsync_v7", {28'(bus_s.vcount), 3'd0, bus_s.vsync}, 112);
            if (k == 112) chk("s.last_hv", {16'(bus_s.hcount), 16'(bus_s.vcount)}, {16'd13, 16'd7});
            if (k == 113) chk("s.wrap", {8'(bus_s.hcount), 8'(bus_s.vcount), 15'd0, bus_s.frame_start}, 1);
            if (k == 656) chk("d.hsync_655", {31'd0, bus_d.hsync}, 1);
            if (k == 657) chk("d.hsync_656", {31'd0, bus_d.hsync}, 0);
            if (k == 752) chk("d.hsync_751", {31'd0, bus_d.hsync}, 0);
            if (k == 753) chk("d.hsync_752", {31'd0, bus_d.hsync}, 1);
            if (k == 801) chk("d.line2", {10'(bus_d.hcount), 10'(bus_d.vcount), 10'd0,
                                          bus_d.line_start, bus_d.frame_start}, {10'd0, 10'd1, 10'd0, 2'b10});
        end
        chk("s.active_per_frame", s_active_cnt, 32);
        chk("d.hsync_low_per_line", d_hsync_cnt, 96);
        chk("d.line_starts", d_ls_cnt, 2);
        chk("s.line_starts", s_ls_cnt, 115);
        chk("s.frame_starts", s_fs_cnt, 15);

        // Enable pattern 1,0,0,1: strobes never last two cycles.
        prev_ls = 1'b0;
        for (int i = 0; i < 200; i++) begin
            en = ((i % 4) == 0 || (i % 4) == 3) ? 1'b1 : 1'b0;
            tick();
            chk("s.ls_consecutive", {31'd0, prev_ls & bus_s.line_start}, 0);
            prev_ls = bus_s.line_start;
        end

        // Reset mid-frame at small (5,3).
        en = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (bus_s.hcount == 4'd5 && bus_s.vcount == 4'd3) found = 1'b1;
        end
        chk("s.reach_5_3", {31'd0, found}, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst.s.hv", {16'(bus_s.hcount), 16'(bus_s.vcount)}, {16'd13, 16'd7});
        chk("midrst.s.levels", {29'd0, bus_s.active, bus_s.hsync, bus_s.vsync}, 0);
        chk("midrst.d.hv", {16'(bus_d.hcount), 16'(bus_d.vcount)}, {16'd799, 16'd524});
        tick();
        reset = 1'b0;
        tick();
        chk("after_rst.s", {8'(bus_s.hcount), 8'(bus_s.vcount), 13'd0,
                            bus_s.active, bus_s.line_start, bus_s.frame_start}, 7);

        // Free run for coherence.
        repeat (300) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator producing horizontal and vertical sync, active-video and pixel-coordinate signals for a VGA-style display. Supersedes the fixed 800-count horizontal-only counter. Horizontal and vertical counters run off a single pixel clock with an optional clock-enable, porch and sync widths set by parameters, and selectable sync polarity. It sits between the pixel-clock domain and the pixel/framebuffer pipeline, which consumes `x`, `y`, `active` and the line/frame strobes.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: horizontal sync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vertical sync width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `SYNC_POL`, 0: asserted level of hsync/vsync (0 = active-low)
- `CW`, 10: counter/coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2**CW; all eight timing parameters ≥ 1
- `clk`  in  1: pixel clock
- `reset`  in  1: asynchronous, active-high reset
- `en`  in  1: pixel-advance enable; counters step only on clk edges with en=1
- `hcount`  out  CW: horizontal position, 0..H_TOTAL-1
- `vcount`  out  CW: vertical position, 0..V_TOTAL-1
- `x`  out  CW: hcount while active, else 0
- `y`  out  CW: vcount while active, else 0
- `active`  out  1: hcount<H_ACTIVE and vcount<V_ACTIVE
- `hsync`  out  1: horizontal sync at SYNC_POL level during the sync window
- `vsync`  out  1: vertical sync at SYNC_POL level during the sync window
- `line_start`  out  1: one-cycle strobe, hcount just became 0
- `frame_start`  out  1: one-cycle strobe, hcount and vcount just became 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order from count 0: active, front porch, sync, back porch. hsync is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync is asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for the whole of each such line.
- On an en=1 edge:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount=V_TOTAL-1 together with the hcount wrap, vcount wraps to 0.
- en=0: all counters and level outputs hold.
- All outputs are registered and mutually coherent. hsync, vsync, active, x and y always correspond to the hcount/vcount values presented in the same cycle; they are decoded from next-state counts, not from the current ones.
- Counter arithmetic is CW bits wide. Wrap is by comparison against TOTAL-1, never by overflow.

## Timing
- Reset values (immediate on reset, async):
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1
  - x=0, y=0, active=0
  - hsync=vsync=~SYNC_POL
  - line_start=frame_start=0
- The first en=1 edge after reset deasserts produces hcount=0, vcount=0, active=1, line_start=1, frame_start=1.
- Latency: 0 cycles between counts and their decoded outputs (same register stage).
- line_start and frame_start are high exactly one clk cycle: set on the advancing edge, cleared on the next clk edge regardless of en. They are never high for consecutive cycles while en is held low.
- frame_start implies line_start in the same cycle.
- Line period = H_TOTAL enabled cycles; frame period = H_TOTAL*V_TOTAL enabled cycles.
- Reset mid-frame returns all outputs to reset values asynchronously. Counting resumes from the reset state; there is no partial-line carry-over.
- Reset has priority over en.

## Test plan
- Defaults, en=1 continuously, from reset:
  - hsync low for hcount 656..751 (96 cycles), line_start every 800 cycles.
  - vsync low for vcount 490..491 (1600 cycles), frame_start every 420000 cycles.
  - active high for exactly 307200 cycles per frame.
- Small config (H 8/2/3/1, V 4/1/2/1, SYNC_POL=1, CW=4), en=1:
  - hsync high at hcount 10..12, vsync high on vcount 5..6.
  - x 0..7 then 0; hcount wraps 13→0 and vcount 7→0 on the same edge, with frame_start high that cycle.
- Small config, en toggling 1,0,0,1 pattern: every output changes only on en=1 edges, and each line/frame strobe lasts one cycle.
- Reset asserted at hcount=5, vcount=3 (small config): outputs return immediately to hcount=13, vcount=7, active=0, hsync=vsync=0. The next en edge gives (0,0) with frame_start=1.
- Coherence check over one full small-config frame: every cycle, active == (hcount<8 && vcount<4), x == (active ? hcount : 0), y == (active ? vcount : 0).
